aes_decrypt_iter: RTL
=====================

// Module: aes_decrypt_iter
// PURPOSE
//  Iterative AES inverse cipher (FIPS-197 InvCipher) for 128/192/256-bit keys; one round per clock.
//  Counterpart of the encrypt path: takes ciphertext plus the same pre-expanded key schedule, returns plaintext.
//  Sits between the key-expansion block and the board display path; valid/ready on both sides.
// PARAMETERS
//  DATA_W   128   block width in bits; fixed by AES, not to be overridden
//  KEY_W    1920  expanded-key bus width: 15 round keys x 128 bits
// PORTS
//  clk        in   1     rising-edge clock
//  rst_n      in   1     asynchronous active-low reset
//  in_valid   in   1     ciphertext offered
//  in_ready   out  1     block can accept a ciphertext (IDLE only)
//  in_data    in   128   ciphertext
//  key_d      in   1920  expanded schedule; round key i = key_d[((nr+1-i)*128-1) -: 128]
//  switch     in   2     key size: 00->nr=10, 01->nr=12, 10/11->nr=14
//  out_valid  out  1     plaintext valid
//  out_ready  in   1     consumer accepts plaintext
//  out_data   out  128   plaintext
//  h1,h2,h3   out  7     seven-segment digits of out_data[7:0] (see CONFIGURATION)
// BEHAVIOUR
//  Reset (async, rst_n=0): FSM=IDLE, in_ready=1, out_valid=0, out_data=0, round counter=0, nr_q=10.
//  FSM IDLE -> ROUND -> DONE -> IDLE.
//  IDLE: in_ready=1. On edge with in_valid=1: state <= in_data ^ rk[nr]; nr_q <= nr(switch); rnd <= nr-1; ->ROUND.
//  ROUND, rnd>0: state <= InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ rk[rnd]); rnd <= rnd-1.
//  ROUND, rnd==0: state <= InvSubBytes(InvShiftRows(state)) ^ rk[0]; ->DONE; out_valid <= 1.
//  Latency: out_valid rises nr edges after the accept edge (10/12/14); in_ready=0 from accept until DONE exits.
//  DONE: out_valid=1, out_data=state held stable; on edge with out_ready=1 -> IDLE, out_valid <= 0.
//  No accept in DONE (in_ready=0): a new block can be accepted the cycle after the out_ready handshake.
//  out_ready ignored outside DONE; in_valid ignored outside IDLE.
//  switch sampled only at accept; changes mid-operation have no effect.
//  key_d is not registered: source holds it stable from accept until out_valid.
//  rnd is 4 bits, counts down, never wraps: leaves ROUND exactly at 0.
//  rst_n low mid-round aborts the operation; partial result is discarded, outputs return to reset values.
// CONFIGURATION
//  SEVEN_SEG_EN defined: SevenSegment instance decodes out_data[7:0] onto h1,h2,h3 (reset shows 0x00).
//  SEVEN_SEG_EN undefined: no decoder instantiated; h1,h2,h3 tied to 7'h00; ports remain for pin-compat.
// STRUCTURE
//  aes_pkg: NR_128/NR_192/NR_256 (10/12/14), SW_128/SW_192/SW_256 codes, FSM state enum,
//   inv_sbox table function, xtime/gf_mul helpers for InvMixColumns, rk_slice(key_d,nr,i) function.
//  Sub-module aes_inv_round: combinational; inputs state, round key, last flag; last=1 skips InvMixColumns.
//  Top holds FSM, rnd counter, nr_q, state register, handshake logic, optional display.
// TESTING
//  Expanded keys come from the bench reference model; vectors are FIPS-197 App. C.
//  AES-128: switch=00, key 000102..0f, in 69c4e0d86a7b0430d8cdb78070b4c55a -> out 00112233445566778899aabbccddeeff, out_valid 10 edges after accept.
//  AES-192: switch=01, key 000102..17, in dda97ca4864cdfe06eaf70a0ec0d7191 -> same plaintext, 12 edges.
//  AES-256: switch=10 and 11, key 000102..1f, in 8ea2b7ca516745bfeafc49904b496089 -> same plaintext, 14 edges.
//  Backpressure: out_ready=0 for 20 cycles -> out_valid/out_data stable, in_ready=0; in_valid pulses ignored.
//  Mid-op reset: rst_n=0 at round 5 -> out_valid=0, in_ready=1, out_data=0 immediately; next block decrypts correctly.
//  Back-to-back: in_valid held high with two blocks -> second accepted the cycle after first out_ready handshake.

Source files
------------

// File: rtl/aes_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg
// Shared constants, FSM state type and GF(2^8) helpers for the iterative AES
// inverse cipher.
//   NR_*        round counts for 128/192/256-bit keys
//   SW_*        key-size select codes on the switch input
//   fsm_t       controller states
//   xtime       multiply by x in GF(2^8) mod x^8+x^4+x^3+x+1
//   gf_mul      general GF(2^8) multiply (used by InvMixColumns)
//   inv_sbox    AES inverse S-box
//   nr_of       switch code -> round count
//   rk_slice    select round key i from the flattened expanded schedule
// -----------------------------------------------------------------------------
package aes_pkg;

   localparam int AES_BLK_W = 128;
   localparam int AES_KEY_W = 1920;

   localparam logic [3:0] NR_128 = 4'd10;
   localparam logic [3:0] NR_192 = 4'd12;
   localparam logic [3:0] NR_256 = 4'd14;

   localparam logic [1:0] SW_128 = 2'b00;
   localparam logic [1:0] SW_192 = 2'b01;
   localparam logic [1:0] SW_256 = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ROUND = 2'd1,
      ST_DONE  = 2'd2
   } fsm_t;

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] t;
      p = 8'h00;
      t = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ t;
         t = xtime(t);
      end
      return p;
   endfunction

   // Multiplicative inverse as a^254 (2^1 + 2^2 + ... + 2^7); 0 maps to 0.
   function automatic logic [7:0] gf_inv(input logic [7:0] a);
      logic [7:0] sq;
      logic [7:0] r;
      sq = a;
      r  = 8'h01;
      for (int k = 1; k < 8; k++) begin
         sq = gf_mul(sq, sq);
         r  = gf_mul(r, sq);
      end
      return r;
   endfunction

   // Inverse S-box built from the inverse affine map followed by the field
   // inverse, so there is no 256-entry literal to keep in sync.
   function automatic logic [7:0] inv_sbox(input logic [7:0] s);
      logic [7:0] b;
      b = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
      return gf_inv(b);
   endfunction

   function automatic logic [3:0] nr_of(input logic [1:0] sw);
      case (sw)
         SW_128:  return NR_128;
         SW_192:  return NR_192;
         SW_256:  return NR_256;
         default: return NR_256;
      endcase
   endfunction

   // Round key i lives at key_d[((nr+1-i)*128-1) -: 128], i.e. bit offset (nr-i)*128.
   function automatic logic [127:0] rk_slice(input logic [AES_KEY_W-1:0] kd,
                                             input logic [3:0] nr,
                                             input logic [3:0] i);
      logic [3:0]  d;
      logic [10:0] base;
      d    = nr - i;
      base = {d, 7'd0};
      return kd[base +: 128];
   endfunction

endpackage

// File: rtl/SevenSegment.sv
// -----------------------------------------------------------------------------
// SevenSegment
// Decimal display of an 8-bit value on three digits (only built when
// SEVEN_SEG_EN is defined). Segment order {g,f,e,d,c,b,a}, active high.
// Ports
//   value  in  8   value to show (0..255)
//   h1     out 7   hundreds digit
//   h2     out 7   tens digit
//   h3     out 7   ones digit
// -----------------------------------------------------------------------------
`ifdef SEVEN_SEG_EN
module SevenSegment (
   input  logic [7:0] value,
   output logic [6:0] h1,
   output logic [6:0] h2,
   output logic [6:0] h3
);

   function automatic logic [6:0] seg(input logic [3:0] d);
      case (d)
         4'd0:    return 7'h3f;
         4'd1:    return 7'h06;
         4'd2:    return 7'h5b;
         4'd3:    return 7'h4f;
         4'd4:    return 7'h66;
         4'd5:    return 7'h6d;
         4'd6:    return 7'h7d;
         4'd7:    return 7'h07;
         4'd8:    return 7'h7f;
         4'd9:    return 7'h6f;
         default: return 7'h00;
      endcase
   endfunction

   logic [7:0] hund;
   logic [7:0] tens;
   logic [7:0] ones;

   assign hund = value / 8'd100;
   assign tens = (value / 8'd10) % 8'd10;
   assign ones = value % 8'd10;

   assign h1 = seg(hund[3:0]);
   assign h2 = seg(tens[3:0]);
   assign h3 = seg(ones[3:0]);

endmodule
`endif

// File: rtl/aes_inv_round.sv
// -----------------------------------------------------------------------------
// aes_inv_round
// One combinational AES inverse round:
//   result = InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ rk)   (last=0)
//   result = InvSubBytes(InvShiftRows(state)) ^ rk                  (last=1)
// Ports
//   state   in  128  current state, byte 0 in [127:120], column-major
//   rk      in  128  round key for this round
//   last    in  1    final round: skip InvMixColumns
//   result  out 128  next state
// -----------------------------------------------------------------------------
module aes_inv_round
   import aes_pkg::*;
(
   input  logic [127:0] state,
   input  logic [127:0] rk,
   input  logic         last,
   output logic [127:0] result
);

   logic [7:0] s  [16];
   logic [7:0] sb [16];
   logic [7:0] ak [16];
   logic [7:0] mc [16];

   always_comb begin
      for (int n = 0; n < 16; n++) begin
         s[n] = state[127-8*n -: 8];
      end
      // Byte (r,c) sits at index r+4c; row r rotates right by r columns.
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            sb[r+4*c] = inv_sbox(s[r+4*((c+4-r)%4)]);
         end
      end
      for (int n = 0; n < 16; n++) begin
         ak[n] = sb[n] ^ rk[127-8*n -: 8];
      end
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            mc[r+4*c] = gf_mul(ak[4*c+r],         8'h0e) ^
                        gf_mul(ak[4*c+(r+1)%4],   8'h0b) ^
                        gf_mul(ak[4*c+(r+2)%4],   8'h0d) ^
                        gf_mul(ak[4*c+(r+3)%4],   8'h09);
         end
      end
      result = '0;
      for (int n = 0; n < 16; n++) begin
         result[127-8*n -: 8] = last ? ak[n] : mc[n];
      end
   end

endmodule

// File: rtl/aes_decrypt_iter.sv
// -----------------------------------------------------------------------------
// aes_decrypt_iter
// Iterative AES inverse cipher for 128/192/256-bit keys, one round per clock,
// using a pre-expanded key schedule. valid/ready handshake on both sides.
// Optional display: define SEVEN_SEG_EN to drive h1..h3 from out_data[7:0];
// otherwise h1..h3 are tied to 0.
// Ports
//   clk        in  1     rising-edge clock
//   rst_n      in  1     asynchronous active-low reset
//   in_valid   in  1     ciphertext offered
//   in_ready   out 1     block can be accepted (IDLE only)
//   in_data    in  128   ciphertext
//   key_d      in  1920  expanded schedule, rk[i] at bit offset (nr-i)*128
//   switch     in  2     key size: 00 AES-128, 01 AES-192, 1x AES-256
//   out_valid  out 1     plaintext valid
//   out_ready  in  1     consumer accepts plaintext
//   out_data   out 128   plaintext
//   h1,h2,h3   out 7     seven-segment digits of out_data[7:0]
//
// state    | meaning
// ST_IDLE  | waiting for ciphertext, in_ready=1
// ST_ROUND | one inverse round per clock, rnd_q counts down to 0
// ST_DONE  | plaintext held on out_data until out_ready
// -----------------------------------------------------------------------------
module aes_decrypt_iter
   import aes_pkg::*;
#(
   parameter int DATA_W = AES_BLK_W,
   parameter int KEY_W  = AES_KEY_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [KEY_W-1:0]  key_d,
   input  logic [1:0]        switch,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [6:0]        h1,
   output logic [6:0]        h2,
   output logic [6:0]        h3
);

   fsm_t              fsm_q;
   logic [3:0]        rnd_q;
   logic [3:0]        nr_q;
   logic [DATA_W-1:0] st_q;
   logic [DATA_W-1:0] out_q;

   logic [3:0]        nr_sel;
   logic [127:0]      rk_cur;
   logic [127:0]      round_out;
   logic              last_rnd;

   assign nr_sel   = nr_of(switch);
   assign rk_cur   = rk_slice(key_d, nr_q, rnd_q);
   assign last_rnd = (rnd_q == 4'd0);

   aes_inv_round u_round (
      .state  (st_q),
      .rk     (rk_cur),
      .last   (last_rnd),
      .result (round_out)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fsm_q     <= ST_IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         out_q     <= '0;
         st_q      <= '0;
         rnd_q     <= 4'd0;
         nr_q      <= NR_128;
      end else begin
         case (fsm_q)
            ST_IDLE: begin
               if (in_valid) begin
                  // rk[nr] is always the lowest 128 bits of the schedule.
                  st_q     <= in_data ^ key_d[127:0];
                  nr_q     <= nr_sel;
                  rnd_q    <= nr_sel - 4'd1;
                  in_ready <= 1'b0;
                  fsm_q    <= ST_ROUND;
               end
            end
            ST_ROUND: begin
               st_q <= round_out;
               if (last_rnd) begin
                  out_q     <= round_out;
                  out_valid <= 1'b1;
                  fsm_q     <= ST_DONE;
               end else begin
                  rnd_q <= rnd_q - 4'd1;
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  fsm_q     <= ST_IDLE;
               end
            end
            default: begin
               fsm_q     <= ST_IDLE;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

   assign out_data = out_q;

`ifdef SEVEN_SEG_EN
   SevenSegment u_seg (
      .value (out_q[7:0]),
      .h1    (h1),
      .h2    (h2),
      .h3    (h3)
   );
`else
   assign h1 = 7'h00;
   assign h2 = 7'h00;
   assign h3 = 7'h00;
`endif

endmodule
